// File: rtl/ddram_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ddram_arb_pkg : shared types and constants for the DDR3 two-port arbiter  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package ddram_arb_pkg;

  // The tag length width must match the arbiter's BCW parameter.
  localparam int TAG_LEN_W = 8;

  localparam logic P_EMU = 1'b0;
  localparam logic P_SYS = 1'b1;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    WLOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 owner;
    logic [TAG_LEN_W-1:0] len;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/ddram_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ddram_arb_if : one Avalon-MM burst link (requester <-> arbiter <-> DDR3)  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface ddram_arb_if #(
  parameter int AW  = 29,
  parameter int DW  = 64,
  parameter int BCW = 8
);
  logic [AW-1:0]   address;
  logic [BCW-1:0]  burstcount;
  logic            read;
  logic            write;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] byteenable;
  logic            waitrequest;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/ddram_arb_tagfifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ddram_arb_tagfifo : in-order FIFO of outstanding read-burst tags          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ddram_arb_tagfifo
  import ddram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic push_i,
  input  tag_t din_i,
  input  logic pop_i,
  output tag_t head_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PW = $clog2(DEPTH);

  tag_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/ddram_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ddram_arb : shares the DDR3 ram1 Avalon-MM port between emu (m0) and a    |
// | system master (m1). DDRAM_ARB_RR_EN selects round-robin tie-breaking.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ddram_arb
  import ddram_arb_pkg::*;
#(
  parameter int AW        = 29,
  parameter int DW        = 64,
  parameter int BCW       = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  ddram_arb_if.slave  m0,
  ddram_arb_if.slave  m1,
  ddram_arb_if.master ram,
  output logic        err_orphan
);
  arb_state_e     state_q, state_d;
  logic           owner_q, owner_d;
  logic [BCW-1:0] wcnt_q, wcnt_d;
  logic [BCW-1:0] rcnt_q, rcnt_d;
  logic           err_q;

  logic [1:0]     req_rd, req_wr, elig;
  logic           gnt, gnt_vld, tie_win, pass;
  logic [BCW-1:0] bc_mux, gnt_len;
  logic           cmd_rd, cmd_wr, acc_rd, acc_wr;
  logic           fifo_full, fifo_empty, rdv_route, pop;
  tag_t           head, push_tag;

  assign req_rd  = {m1.read,  m0.read};
  assign req_wr  = {m1.write, m0.write};
  assign elig    = req_wr | (req_rd & ~{2{fifo_full}});
  assign bc_mux  = gnt ? m1.burstcount : m0.burstcount;
  assign gnt_len = (bc_mux == '0) ? BCW'(1) : bc_mux;

`ifdef DDRAM_ARB_RR_EN
  logic last_q, last_d;

  assign tie_win = ~last_q;

  // A command is finished on a read accept or on the final beat of a write.
  always_comb begin
    last_d = last_q;
    if (acc_rd) last_d = gnt;
    if (acc_wr && (state_q == ARB) && (gnt_len == BCW'(1))) last_d = gnt;
    if (acc_wr && (state_q == WLOCK) && (wcnt_q == BCW'(1))) last_d = gnt;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) last_q <= P_SYS;
    else       last_q <= last_d;
  end
`else
  assign tie_win = P_EMU;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wcnt_d  = wcnt_q;
    gnt_vld = 1'b0;
    gnt     = P_EMU;
    unique case (state_q)
      ARB: begin
        gnt_vld = |elig;
        gnt     = (&elig) ? tie_win : (elig[1] ? P_SYS : P_EMU);
        if (acc_wr && (gnt_len > BCW'(1))) begin
          state_d = WLOCK;
          owner_d = gnt;
          wcnt_d  = gnt_len - BCW'(1);
        end
      end
      WLOCK: begin
        gnt_vld = 1'b1;
        gnt     = owner_q;
        if (acc_wr) begin
          wcnt_d = wcnt_q - BCW'(1);
          if (wcnt_q == BCW'(1)) state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Reads are never issued while a write burst holds the port.
  assign cmd_wr = ~reset & gnt_vld & req_wr[gnt];
  assign cmd_rd = ~reset & gnt_vld & (state_q == ARB) & ~req_wr[gnt]
                  & req_rd[gnt] & ~fifo_full;
  assign acc_wr = cmd_wr & ~ram.waitrequest;
  assign acc_rd = cmd_rd & ~ram.waitrequest;
  assign pass   = ~reset & gnt_vld & ((state_q == ARB) | req_wr[gnt]);

  assign ram.address    = gnt ? m1.address    : m0.address;
  assign ram.burstcount = bc_mux;
  assign ram.writedata  = gnt ? m1.writedata  : m0.writedata;
  assign ram.byteenable = gnt ? m1.byteenable : m0.byteenable;
  assign ram.read       = cmd_rd;
  assign ram.write      = cmd_wr;

  assign m0.waitrequest = ~(pass & (gnt == P_EMU)) | ram.waitrequest;
  assign m1.waitrequest = ~(pass & (gnt == P_SYS)) | ram.waitrequest;

  assign push_tag.owner = gnt;
  assign push_tag.len   = gnt_len;

  ddram_arb_tagfifo #(.DEPTH(TAG_DEPTH)) u_tagfifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push_i  (acc_rd),
    .din_i   (push_tag),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rdv_route = ~reset & ram.readdatavalid & ~fifo_empty;
  assign pop       = rdv_route & ((rcnt_q + BCW'(1)) == head.len);

  always_comb begin
    rcnt_d = rcnt_q;
    if (rdv_route) rcnt_d = pop ? '0 : rcnt_q + BCW'(1);
  end

  assign m0.readdata      = ram.readdata;
  assign m1.readdata      = ram.readdata;
  assign m0.readdatavalid = rdv_route & (head.owner == P_EMU);
  assign m1.readdatavalid = rdv_route & (head.owner == P_SYS);
  assign err_orphan       = err_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ARB;
      owner_q <= P_EMU;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      err_q   <= err_q | (ram.readdatavalid & fifo_empty);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ddram_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ddram_arb : randomized bench for ddram_arb against a queue-based model |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_ddram_arb;
  localparam int AW = 29, DW = 64, BCW = 8, TAG_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic err_orphan;
  always #5 clk = ~clk;

  ddram_arb_if #(.AW(AW), .DW(DW), .BCW(BCW)) m0_if ();
  ddram_arb_if #(.AW(AW), .DW(DW), .BCW(BCW)) m1_if ();
  ddram_arb_if #(.AW(AW), .DW(DW), .BCW(BCW)) ram_if ();

  ddram_arb #(.AW(AW), .DW(DW), .BCW(BCW), .TAG_DEPTH(TAG_DEPTH)) u_dut (
    .clk_sys    (clk),
    .reset      (rst),
    .m0         (m0_if),
    .m1         (m1_if),
    .ram        (ram_if),
    .err_orphan (err_orphan)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus for the current cycle
  logic           rd_v [2], wr_v [2];
  logic [AW-1:0]  ad_v [2];
  logic [BCW-1:0] bc_v [2];
  logic [DW-1:0]  wd_v [2];
  logic [7:0]     be_v [2];
  logic           wt_v, rdv_v, rst_v;
  logic [DW-1:0]  rdata_v;

  // Reference model: lock owner/remaining beats, queue of outstanding bursts
  typedef struct { bit own; int len; } tag_m_t;
  tag_m_t q[$];
  bit lk, lk_own, last, err_m;
  int lk_rem, hcnt;

  function automatic int eff(input logic [BCW-1:0] b);
    return (b == 0) ? 1 : int'(b);
  endfunction

  task automatic model_reset();
    q.delete();
    lk = 0; lk_own = 0; lk_rem = 0; hcnt = 0; last = 1; err_m = 0;
  endtask

  task automatic apply();
    rst = rst_v;
    m0_if.read = rd_v[0]; m0_if.write = wr_v[0]; m0_if.address = ad_v[0];
    m0_if.burstcount = bc_v[0]; m0_if.writedata = wd_v[0]; m0_if.byteenable = be_v[0];
    m1_if.read = rd_v[1]; m1_if.write = wr_v[1]; m1_if.address = ad_v[1];
    m1_if.burstcount = bc_v[1]; m1_if.writedata = wd_v[1]; m1_if.byteenable = be_v[1];
    ram_if.waitrequest = wt_v; ram_if.readdatavalid = rdv_v; ram_if.readdata = rdata_v;
  endtask

  task automatic set_idle();
    rst_v = 0; wt_v = 0; rdv_v = 0; rdata_v = '0;
    for (int p = 0; p < 2; p++) begin
      rd_v[p] = 0; wr_v[p] = 0; ad_v[p] = AW'(p * 'h100 + 'h100);
      bc_v[p] = 8'd1; wd_v[p] = '0; be_v[p] = 8'hFF;
    end
  endtask

  task automatic eval();
    bit full, gv, g, e_rd, e_wr, acc;
    bit el [2];
    bit e_wt [2], e_rdv [2];
    if (rst_v) begin
      check_eq("rst_ram_read", ram_if.read, 0);
      check_eq("rst_ram_write", ram_if.write, 0);
      check_eq("rst_m0_wait", m0_if.waitrequest, 1);
      check_eq("rst_m1_wait", m1_if.waitrequest, 1);
      check_eq("rst_m0_rdv", m0_if.readdatavalid, 0);
      check_eq("rst_m1_rdv", m1_if.readdatavalid, 0);
      check_eq("rst_err", err_orphan, 64'(err_m));
      model_reset();
      return;
    end
    full = (q.size() == TAG_DEPTH);
    for (int p = 0; p < 2; p++) el[p] = wr_v[p] || (rd_v[p] && !full);
    gv = 1; g = 0;
    if (lk) g = lk_own;
    else if (el[0] && el[1]) begin
`ifdef DDRAM_ARB_RR_EN
      g = !last;
`else
      g = 0;
`endif
    end
    else if (el[0]) g = 0;
    else if (el[1]) g = 1;
    else gv = 0;
    e_wr = gv && wr_v[g];
    e_rd = gv && !lk && !wr_v[g] && rd_v[g] && !full;
    for (int p = 0; p < 2; p++) begin
      e_wt[p]  = (gv && g == p && (!lk || wr_v[p])) ? wt_v : 1'b1;
      e_rdv[p] = rdv_v && q.size() > 0 && q[0].own == p;
    end
    check_eq("ram_write", ram_if.write, 64'(e_wr));
    check_eq("ram_read", ram_if.read, 64'(e_rd));
    check_eq("m0_wait", m0_if.waitrequest, 64'(e_wt[0]));
    check_eq("m1_wait", m1_if.waitrequest, 64'(e_wt[1]));
    check_eq("m0_rdv", m0_if.readdatavalid, 64'(e_rdv[0]));
    check_eq("m1_rdv", m1_if.readdatavalid, 64'(e_rdv[1]));
    check_eq("err_orphan", err_orphan, 64'(err_m));
    if (e_wr || e_rd) begin
      check_eq("ram_address", ram_if.address, 64'(ad_v[g]));
      check_eq("ram_burstcount", ram_if.burstcount, 64'(bc_v[g]));
    end
    if (e_wr) begin
      check_eq("ram_writedata", ram_if.writedata, wd_v[g]);
      check_eq("ram_byteenable", ram_if.byteenable, 64'(be_v[g]));
    end
    if (rdv_v) begin
      check_eq("m0_readdata", m0_if.readdata, rdata_v);
      check_eq("m1_readdata", m1_if.readdata, rdata_v);
    end
    // advance the model to the state after the coming clock edge
    acc = (e_wr || e_rd) && !wt_v;
    if (rdv_v) begin
      if (q.size() == 0) err_m = 1;
      else begin
        hcnt++;
        if (hcnt == q[0].len) begin
          void'(q.pop_front());
          hcnt = 0;
        end
      end
    end
    if (acc && e_rd) begin
      q.push_back('{own: g, len: eff(bc_v[g])});
      last = g;
    end
    if (acc && e_wr) begin
      if (lk) begin
        lk_rem--;
        if (lk_rem == 0) begin lk = 0; last = g; end
      end else if (eff(bc_v[g]) > 1) begin
        lk = 1; lk_own = g; lk_rem = eff(bc_v[g]) - 1;
      end else last = g;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    apply();
    #1;
    eval();
  endtask

  task automatic randomize_inputs();
    int mode;
    rst_v = ($urandom_range(0, 399) == 0);
    for (int p = 0; p < 2; p++) begin
      mode    = $urandom_range(0, 9);
      rd_v[p] = (mode <= 3);
      wr_v[p] = (mode >= 7) || (mode == 3);
      ad_v[p] = AW'($urandom);
      bc_v[p] = BCW'($urandom_range(0, 4));
      wd_v[p] = {$urandom, $urandom};
      be_v[p] = 8'($urandom);
    end
    wt_v    = ($urandom_range(0, 3) == 0);
    rdv_v   = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 79) == 0);
    rdata_v = {$urandom, $urandom};
  endtask

  initial begin
    set_idle();
    rst_v = 1;
    apply();
    model_reset();
    repeat (2) @(posedge clk);

    // checked reset cycle
    cycle();
    set_idle();

    // m0 read burst of 4, then four return beats
    rd_v[0] = 1; bc_v[0] = 8'd4;
    cycle();
    rd_v[0] = 0;
    repeat (4) begin rdv_v = 1; rdata_v = {$urandom, $urandom}; cycle(); end
    rdv_v = 0;

    // m0 write burst of 8 while m1 requests a read from beat 2
    wr_v[0] = 1; bc_v[0] = 8'd8;
    for (int i = 0; i < 12; i++) begin
      rd_v[1] = (i >= 1);
      if (i == 8) wr_v[0] = 0;
      cycle();
    end
    rd_v[1] = 0;

    // interleaved reads m0 len2, m1 len3, m0 len1, then six beats
    rd_v[0] = 1; bc_v[0] = 8'd2; cycle(); rd_v[0] = 0;
    rd_v[1] = 1; bc_v[1] = 8'd3; cycle(); rd_v[1] = 0;
    rd_v[0] = 1; bc_v[0] = 8'd1; cycle(); rd_v[0] = 0;
    repeat (6) begin rdv_v = 1; cycle(); end
    rdv_v = 0;

    // fill tag FIFO and hold off a fifth read until the first burst returns
    rd_v[0] = 1; bc_v[0] = 8'd2;
    repeat (6) cycle();
    repeat (4) begin rdv_v = (q.size() > 0); cycle(); end

    // both ports read continuously; tie-breaking shows up in the grants
    rd_v[1] = 1; bc_v[0] = 8'd1; bc_v[1] = 8'd1;
    for (int i = 0; i < 16; i++) begin rdv_v = (q.size() > 0); cycle(); end
    rd_v[0] = 0; rd_v[1] = 0;
    for (int i = 0; i < 12; i++) begin rdv_v = (q.size() > 0); cycle(); end

    // orphan beat, then reset in the middle of a write burst
    rdv_v = 1; cycle(); rdv_v = 0; cycle();
    wr_v[1] = 1; bc_v[1] = 8'd6; cycle(); cycle();
    rst_v = 1; cycle(); rst_v = 0; wr_v[1] = 0;
    rdv_v = 1; cycle(); rdv_v = 0; cycle();
    rst_v = 1; cycle(); rst_v = 0; cycle();

    for (int i = 0; i < 4000; i++) begin
      randomize_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
